collision_monitor: RTL
======================

# collision_monitor

Parametrised collision detector for the LED-matrix Flappy Bird game. It sits between the frame composer (red = bird layer, green = pipe layer) and the game controller. It samples the bird row once per game tick and requires a collision to persist across a configurable number of ticks before counting it as a hit. It also manages a lives counter, a post-hit invulnerability window, and a latched death state that only an explicit restart clears.

## Interface
- WIDTH, 16, matrix columns per row (≥2)
- HEIGHT, 16, matrix rows (≥2)
- BIRD_ROW, 11, row index the bird occupies (< HEIGHT)
- CONFIRM, 2, consecutive overlapping ticks needed for a hit (≥1)
- LIVES, 3, lives loaded at reset/restart (≥1)
- GRACE, 4, invulnerable ticks after a non-fatal hit (≥1)

- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle game-frame strobe; the only sampling instant
- restart  input  1  one-cycle request to start a new game
- RedPixels  input  [HEIGHT-1:0][WIDTH-1:0]  bird layer
- GrnPixels  input  [HEIGHT-1:0][WIDTH-1:0]  pipe layer
- hit  output  1  one-cycle pulse per confirmed hit (fatal or not)
- dead  output  1  level, set on last life lost, held until restart
- invuln  output  1  high while in GRACE
- lives_left  output  $clog2(LIVES+1)  remaining lives
- hit_col  output  $clog2(WIDTH)  lowest overlapping column at last hit

## Operation
- Overlap vector ov = RedPixels[BIRD_ROW] & GrnPixels[BIRD_ROW]. any_ov = |ov. Both are combinational.
- States: ALIVE, GRACE, DEAD.
- ALIVE, on tick:
  - If any_ov is low: conf_cnt ← 0.
  - If any_ov is high and conf_cnt+1 < CONFIRM: conf_cnt increments.
  - If any_ov is high and conf_cnt+1 == CONFIRM: this is a hit. Pulse hit, decrement lives_left, capture hit_col = lowest set index of ov, clear conf_cnt.
  - After a hit: go to DEAD if lives_left was 1, otherwise go to GRACE with grace_cnt ← GRACE.
- GRACE: overlap is ignored. Each tick decrements grace_cnt. The tick that takes grace_cnt to 0 returns the block to ALIVE, with conf_cnt at 0.
- DEAD: all ticks are ignored. dead=1 and lives_left=0 hold.
- restart, from any state: next state ALIVE, lives_left ← LIVES, conf_cnt ← 0, grace_cnt ← 0, dead ← 0, hit_col ← 0.
- Cycles without tick change no state. Overlap on a non-tick cycle is irrelevant.
- Reset values: state ALIVE, hit=0, dead=0, invuln=0, lives_left=LIVES, hit_col=0, all counters 0.
- Counter widths: conf_cnt is $clog2(CONFIRM+1) bits, grace_cnt is $clog2(GRACE+1) bits. Neither counter wraps; conf_cnt clears at CONFIRM.

## Timing
- All outputs are registered. hit, dead, invuln, lives_left and hit_col update on the edge that samples the tick. They are visible in the cycle after tick is high, i.e. latency 1.
- hit is exactly one cycle wide, even if tick is held high for multiple cycles. Each high tick cycle counts as one tick.
- restart and tick in the same cycle: restart wins and that tick is discarded.
- restart in the same cycle as a hit-producing tick: no hit pulse, lives reload.
- reset_n assertion mid-game: everything returns to reset values asynchronously. The first tick after release is sampled normally.
- CONFIRM=1: a hit is produced on the first overlapping tick.

## Configuration
- COLLISION_GRACE_EN defined: GRACE state and grace_cnt exist as described above.
- COLLISION_GRACE_EN undefined: a non-fatal hit returns directly to ALIVE with conf_cnt=0. invuln is tied to 0, the GRACE parameter is ignored, and no grace counter is synthesised.

## Structure
- Package collision_pkg: state enum typedef (ALIVE, GRACE, DEAD) and a lowest-set-index function reused by other matrix blocks.
- One sub-module: lsb_index, a WIDTH-parametrised priority encoder feeding hit_col.
- The FSM, counters and output registers live in collision_monitor.

## Test plan
- Defaults. Overlap at row 11 col 5 on 2 consecutive ticks → hit pulse one cycle after the 2nd tick, lives_left 3→2, hit_col=5, invuln=1.
- Overlap on tick 1, clear on tick 2, overlap on tick 3 → no hit; conf_cnt restarts. Overlap on tick 4 → hit.
- After a hit, overlap held for 4 ticks → no further hit, invuln drops after the 4th tick. Overlap continues for 2 more ticks → second hit, lives_left=1.
- Third confirmed hit → dead=1, lives_left=0. Further overlapping ticks → no hit. restart → dead=0, lives_left=3.
- Overlap at cols 3 and 9, plus overlap in row 10 only → hit_col=3; the row 10 overlap alone produces no hit.
- reset_n pulsed low with conf_cnt=1 → all outputs return to reset values immediately. restart+tick together with overlap → no hit.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and helpers for the LED-matrix game blocks.
//   state_t          : collision FSM states (ALIVE, GRACE, DEAD)
//   LSB_MAX_W        : widest vector lowest_set_index accepts
//   lowest_set_index : index of the lowest set bit (0 when the vector is empty)
package collision_pkg;

    typedef enum logic [1:0] {
        ALIVE,
        GRACE,
        DEAD
    } state_t;

    localparam int unsigned LSB_MAX_W = 256;

    function automatic int unsigned lowest_set_index(input logic [LSB_MAX_W-1:0] vec);
        int unsigned idx;
        idx = 0;
        // Scan from the top so the last match written is the lowest set bit.
        for (int unsigned i = LSB_MAX_W; i > 0; i--) begin
            if (vec[i-1]) idx = i - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/lsb_index.sv
// Priority encoder: index of the lowest set bit of a WIDTH-bit vector.
// Ports:
//   vec : input  [WIDTH-1:0]          vector to encode
//   idx : output [$clog2(WIDTH)-1:0]  lowest set index (0 when vec is empty)
module lsb_index #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] idx
);
    import collision_pkg::*;

    localparam int unsigned IW = $clog2(WIDTH);

    logic [LSB_MAX_W-1:0] vec_ext;

    always_comb begin
        vec_ext            = '0;
        vec_ext[WIDTH-1:0] = vec;
        idx                = IW'(lowest_set_index(vec_ext));
    end

endmodule

// File: rtl/collision_monitor.sv
// Collision monitor for the LED-matrix Flappy Bird game.
// Samples bird/pipe overlap on the bird row once per tick, confirms a hit
// after CONFIRM consecutive overlapping ticks, tracks lives, and latches
// death until restart.
// Optional feature: define COLLISION_GRACE_EN to add the post-hit
// invulnerability window (GRACE state, grace counter, invuln output).
// Ports:
//   clk        : in   system clock
//   reset_n    : in   asynchronous active-low reset
//   tick       : in   game-frame strobe, the only sampling instant
//   restart    : in   start a new game (wins over tick)
//   RedPixels  : in   bird layer   [HEIGHT-1:0][WIDTH-1:0]
//   GrnPixels  : in   pipe layer   [HEIGHT-1:0][WIDTH-1:0]
//   hit        : out  one-cycle pulse per confirmed hit
//   dead       : out  high from last life lost until restart
//   invuln     : out  high while invulnerable after a hit
//   lives_left : out  remaining lives
//   hit_col    : out  lowest overlapping column at the last hit
module collision_monitor #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned HEIGHT   = 16,
    parameter int unsigned BIRD_ROW = 11,
    parameter int unsigned CONFIRM  = 2,
    parameter int unsigned LIVES    = 3,
    parameter int unsigned GRACE    = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           tick,
    input  logic                           restart,
    input  logic [HEIGHT-1:0][WIDTH-1:0]   RedPixels,
    input  logic [HEIGHT-1:0][WIDTH-1:0]   GrnPixels,
    output logic                           hit,
    output logic                           dead,
    output logic                           invuln,
    output logic [$clog2(LIVES+1)-1:0]     lives_left,
    output logic [$clog2(WIDTH)-1:0]       hit_col
);
    import collision_pkg::*;

    localparam int unsigned LW = $clog2(LIVES + 1);
    localparam int unsigned CW = $clog2(CONFIRM + 1);
    localparam int unsigned HW = $clog2(WIDTH);

    state_t          state, state_nx;
    logic [CW-1:0]   conf_cnt, conf_nx;
    logic [LW-1:0]   lives_nx;
    logic [HW-1:0]   col_nx, ov_idx;
    logic            hit_nx;
    logic [WIDTH-1:0] ov;
    logic            any_ov;

    // Only the bird row matters; the rest of the frame is deliberately ignored.
    logic unused_rows;
    assign unused_rows = ^{RedPixels, GrnPixels};

    assign ov     = RedPixels[BIRD_ROW] & GrnPixels[BIRD_ROW];
    assign any_ov = |ov;

    lsb_index #(.WIDTH(WIDTH)) u_lsb_index (
        .vec (ov),
        .idx (ov_idx)
    );

`ifdef COLLISION_GRACE_EN
    localparam int unsigned GW = $clog2(GRACE + 1);
    logic [GW-1:0] grace_cnt, grace_nx;
`else
    logic unused_grace;
    assign unused_grace = (GRACE != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ALIVE;
            conf_cnt   <= '0;
            lives_left <= LW'(LIVES);
            hit        <= 1'b0;
            hit_col    <= '0;
`ifdef COLLISION_GRACE_EN
            grace_cnt  <= '0;
`endif
        end else begin
            state      <= state_nx;
            conf_cnt   <= conf_nx;
            lives_left <= lives_nx;
            hit        <= hit_nx;
            hit_col    <= col_nx;
`ifdef COLLISION_GRACE_EN
            grace_cnt  <= grace_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        conf_nx  = conf_cnt;
        lives_nx = lives_left;
        col_nx   = hit_col;
        hit_nx   = 1'b0;
`ifdef COLLISION_GRACE_EN
        grace_nx = grace_cnt;
`endif
        if (restart) begin
            state_nx = ALIVE;
            conf_nx  = '0;
            lives_nx = LW'(LIVES);
            col_nx   = '0;
`ifdef COLLISION_GRACE_EN
            grace_nx = '0;
`endif
        end else if (tick) begin
            case (state)
                ALIVE: begin
                    if (!any_ov) begin
                        conf_nx = '0;
                    end else if (conf_cnt == CW'(CONFIRM - 1)) begin
                        hit_nx   = 1'b1;
                        lives_nx = lives_left - 1'b1;
                        col_nx   = ov_idx;
                        conf_nx  = '0;
                        if (lives_left == LW'(1)) begin
                            state_nx = DEAD;
                        end else begin
`ifdef COLLISION_GRACE_EN
                            state_nx = collision_pkg::GRACE;
                            grace_nx = GW'(GRACE);
`else
                            state_nx = ALIVE;
`endif
                        end
                    end else begin
                        conf_nx = conf_cnt + 1'b1;
                    end
                end
`ifdef COLLISION_GRACE_EN
                collision_pkg::GRACE: begin
                    if (grace_cnt <= GW'(1)) begin
                        state_nx = ALIVE;
                        grace_nx = '0;
                        conf_nx  = '0;
                    end else begin
                        grace_nx = grace_cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign dead = (state == DEAD);
`ifdef COLLISION_GRACE_EN
    assign invuln = (state == collision_pkg::GRACE);
`else
    assign invuln = 1'b0;
`endif

endmodule
